// File: rtl/sum_bcd_scan_pkg.sv
// ----------------------------------------------------------------------------
// sum_bcd_scan_pkg
// Shared definitions for the adder output stage: converter FSM states,
// digit and step counts, and the active-low 7-segment patterns.
// Segment constants are ordered {g,f,e,d,c,b,a}; a 0 lights a segment.
// ----------------------------------------------------------------------------
package sum_bcd_scan_pkg;

    // Converter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Three BCD digits cover the 0..127 range of a 7-bit sum
    localparam int NUM_DIGITS = 3;

    // One shift-add-3 step per input bit
    localparam int STEP_COUNT = 7;

    // Active-low segment patterns, bit6 = g ... bit0 = a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sum_bcd_scan_seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD digit to active-low 7-segment decoder, shared by all
// three display slots.
//   digit in  4 : BCD code; 10..15 show blank
//   blank in  1 : force all segments off (leading-zero blanking)
//   seg   out 7 : active-low segments, bit0 = a ... bit6 = g
// ----------------------------------------------------------------------------
module seg7_decode
    import sum_bcd_scan_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Look up the segment pattern for the current digit. Blanking and
    // non-decimal codes both fall through to all segments off.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sum_bcd_scan.sv
// ----------------------------------------------------------------------------
// sum_bcd_scan
// Output stage for the 6-bit adder: converts the 7-bit binary sum into three
// BCD digits with a sequential shift-add-3 engine and scans them onto a
// common-anode 3-digit 7-segment display with leading-zero blanking.
//   SCAN_DIV      : clock cycles per digit slot (>= 2)
//   clk     in  1 : clock, rising edge
//   rst_n   in  1 : asynchronous active-low reset
//   sum_in  in  7 : binary value, sampled when a load is accepted
//   load    in  1 : conversion request, ignored while busy
//   busy    out 1 : conversion in progress
//   done    out 1 : one-cycle pulse, bcd has just been updated
//   bcd     out 12: {hundreds, tens, ones} registered result
//   seg     out 7 : active-low segments, bit0 = a ... bit6 = g
//   an      out 3 : active-low digit enables, an[0] = hundreds
// ----------------------------------------------------------------------------
module sum_bcd_scan
    import sum_bcd_scan_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  sum_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0] LAST_STEP = 3'(STEP_COUNT - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             step;
    logic             finish;

    logic [6:0]       shift_reg;
    logic [11:0]      scratch;
    logic [2:0]       step_cnt;
    logic [7:0]       adj_low;
    logic [11:0]      scratch_next;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       cur_digit;
    logic             cur_blank;

    // State register for the converter FSM; reset drops any conversion in
    // flight so no done pulse can follow a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the three datapath strobes. DONE always returns
    // to IDLE, so with load held high the next request is taken in the
    // cycle where done is visible, giving one conversion every nine cycles.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (step_cnt == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Add-3 correction ahead of each shift. Only tens and ones need it: with
    // a 7-bit input the hundreds digit never exceeds 1 during conversion,
    // and its top bit is simply shifted out of range.
    always_comb begin
        adj_low = scratch[7:0];
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj_low[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_next = {scratch[10:8], adj_low, shift_reg[6]};
    end

    // Conversion datapath: capture on accept, one corrected shift per SHIFT
    // cycle, and publish the scratch digits to bcd only on finish so the
    // display never sees a partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            scratch   <= '0;
            step_cnt  <= '0;
            bcd       <= '0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                shift_reg <= sum_in;
                scratch   <= '0;
                step_cnt  <= '0;
            end else if (step) begin
                scratch   <= scratch_next;
                shift_reg <= {shift_reg[5:0], 1'b0};
                step_cnt  <= step_cnt + 3'd1;
            end
            if (finish) begin
                bcd <= scratch;
            end
        end
    end

    // Free-running scan divider; each wrap moves the display to the next
    // digit slot, cycling hundreds, tens, ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            digit_idx <= 2'd0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Pick the digit for the active slot and decide leading-zero blanking;
    // a blanked slot keeps its anode enabled but shows no segments.
    always_comb begin
        cur_digit = bcd[3:0];
        cur_blank = 1'b0;
        an        = 3'b011;
        case (digit_idx)
            2'd0: begin
                cur_digit = bcd[11:8];
                cur_blank = (bcd[11:8] == 4'd0);
                an        = 3'b110;
            end
            2'd1: begin
                cur_digit = bcd[7:4];
                cur_blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
                an        = 3'b101;
            end
            default: begin
                cur_digit = bcd[3:0];
                cur_blank = 1'b0;
                an        = 3'b011;
            end
        endcase
    end

    seg7_decode u_decode (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg)
    );

endmodule
